// File: rtl/systolic_tile_sequencer.sv
// Sequences one output-stationary tile: clear, K operand reads with a skewed valid
// wavefront, fixed flush, then row drain. Optional performance counters: SEQ_PERF_CNT_EN.
module systolic_tile_sequencer #(
  parameter int N      = 4,
  parameter int K_W    = 8,
  parameter int ADDR_W = 10,
  localparam int DR_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  output logic              busy,
  output logic              done,
  output logic              clear_acc,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  output logic [N-1:0]      feed_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DR_W-1:0]   drain_row,
  output logic [31:0]       cycle_count,
  output logic [31:0]       stall_count
);

  localparam int FL_W = $clog2(2 * N) + 1;
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2 * N - 1);
  localparam logic [DR_W-1:0] ROW_LAST   = DR_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [K_W-1:0]  k_last_q, k_last_d;
  logic [K_W-1:0]  kcnt_q, kcnt_d;
  logic [FL_W-1:0] fcnt_q, fcnt_d;
  logic [DR_W-1:0] row_q, row_d;
  logic [N-1:0]    skew_q, skew_d;
  logic [N:0]      skew_ext;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clear_acc_q, clear_acc_d;
  logic            rd_en_q, rd_en_d;
  logic            out_valid_q, out_valid_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d  = state_q;
    k_last_d = k_last_q;
    kcnt_d   = kcnt_q;
    fcnt_d   = fcnt_q;
    row_d    = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != {K_W{1'b0}}) begin
            state_d  = S_CLEAR;
            k_last_d = k_len - K_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        kcnt_d  = {K_W{1'b0}};
      end
      S_FEED: begin
        // The counter doubles as the read address and returns to zero on exit.
        if (kcnt_q == k_last_q) begin
          state_d = S_FLUSH;
          kcnt_d  = {K_W{1'b0}};
          fcnt_d  = {FL_W{1'b0}};
        end else begin
          kcnt_d = kcnt_q + K_W'(1);
        end
      end
      S_FLUSH: begin
        if (fcnt_q == FLUSH_LAST) begin
          state_d = S_DRAIN;
          row_d   = {DR_W{1'b0}};
        end else begin
          fcnt_d = fcnt_q + FL_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
            row_d   = {DR_W{1'b0}};
          end else begin
            row_d = row_q + DR_W'(1);
          end
        end else begin
          row_d = row_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    skew_ext    = {skew_q, rd_en_q};
    skew_d      = skew_ext[N-1:0];
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    clear_acc_d = (state_d == S_CLEAR);
    rd_en_d     = (state_d == S_FEED);
    out_valid_d = (state_d == S_DRAIN);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_last_q    <= {K_W{1'b0}};
      kcnt_q      <= {K_W{1'b0}};
      fcnt_q      <= {FL_W{1'b0}};
      row_q       <= {DR_W{1'b0}};
      skew_q      <= {N{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_acc_q <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_last_q    <= k_last_d;
      kcnt_q      <= kcnt_d;
      fcnt_q      <= fcnt_d;
      row_q       <= row_d;
      skew_q      <= skew_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clear_acc_q <= clear_acc_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign clear_acc  = clear_acc_q;
  assign a_rd_en    = rd_en_q;
  assign b_rd_en    = rd_en_q;
  assign a_rd_addr  = ADDR_W'(kcnt_q);
  assign b_rd_addr  = ADDR_W'(kcnt_q);
  assign feed_valid = skew_q;
  assign out_valid  = out_valid_q;
  assign drain_row  = row_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Counters restart on an accepted start and freeze once back in IDLE
  always_comb begin
    cycle_count_d = cycle_count_q;
    stall_count_d = stall_count_q;
    if ((state_q == S_IDLE) && start) begin
      cycle_count_d = 32'd1;
      stall_count_d = 32'd0;
    end else begin
      if (state_d != S_IDLE) begin
        cycle_count_d = cycle_count_q + 32'd1;
      end else begin
        cycle_count_d = cycle_count_q;
      end
      if ((state_q == S_DRAIN) && !out_ready) begin
        stall_count_d = stall_count_q + 32'd1;
      end else begin
        stall_count_d = stall_count_q;
      end
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign stall_count = stall_count_q;
`else
  assign cycle_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench: the stimulus side plans each tile's event timeline from the cycle
// formulas and queues it; a negedge monitor pops and compares whatever the DUT presents.
module tb_systolic_tile_sequencer;

  localparam int N      = 4;
  localparam int K_W    = 8;
  localparam int ADDR_W = 10;
  localparam int DR_W   = 2;

  localparam int EV_CLEAR = 0;
  localparam int EV_RD    = 1;
  localparam int EV_ROW   = 2;
  localparam int EV_DONE  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [K_W-1:0]    k_len;
  logic              busy, done, clear_acc;
  logic              a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [N-1:0]      feed_valid;
  logic              out_valid, out_ready;
  logic [DR_W-1:0]   drain_row;
  logic [31:0]       cycle_count, stall_count;

  systolic_tile_sequencer #(.N(N), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .clear_acc(clear_acc),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .feed_valid(feed_valid), .out_valid(out_valid), .out_ready(out_ready),
    .drain_row(drain_row), .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int val;
    int val2;
  } evt_t;

  evt_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  bit   mon_en       = 1'b0;
  bit   cur_valid    = 1'b0;
  int   cur_t0, cur_k, cur_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int v, input int v2);
    evt_t e;
    e.kind = kind; e.cyc = c; e.val = v; e.val2 = v2;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int v, input int v2);
    evt_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL event: got kind %0d val %0d/%0d at cycle %0d, required nothing", kind, v, v2, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != v || e.val2 != v2) begin
        tests_failed++;
        $display("FAIL event: got kind %0d cycle %0d val %0d/%0d, required kind %0d cycle %0d val %0d/%0d",
                 kind, cyc, v, v2, e.kind, e.cyc, e.val, e.val2);
      end
    end
  endtask

  // Monitor: per-cycle busy / wavefront model plus scoreboard pops on DUT events
  always @(negedge clk) begin
    logic [N-1:0] fv_exp;
    logic         busy_exp;
    if (mon_en) begin
      fv_exp   = '0;
      busy_exp = 1'b0;
      if (cur_valid) begin
        busy_exp = (cyc >= cur_t0 + 1) && (cyc <= cur_t0 + cur_last);
        for (int i = 0; i < N; i++)
          if (cyc >= cur_t0 + 3 + i && cyc <= cur_t0 + cur_k + 2 + i && cyc <= cur_t0 + cur_last)
            fv_exp[i] = 1'b1;
      end
      check("busy", 64'(busy), 64'(busy_exp));
      check("feed_valid", 64'(feed_valid), 64'(fv_exp));
      check("b_port", {b_rd_en, b_rd_addr}, {a_rd_en, a_rd_addr});
      if (clear_acc) pop_check(EV_CLEAR, 0, 0);
      if (a_rd_en)   pop_check(EV_RD, int'(a_rd_addr), 0);
      if (out_valid) pop_check(EV_ROW, int'(drain_row), 0);
      if (done)      pop_check(EV_DONE, int'(cycle_count), int'(stall_count));
    end
  end

  // mode 0: always ready, 1: random ready, 2: three stalls while row 1 is presented
  task automatic run_tile(input int k, input int mode, input int abort_rel);
    int t0, c, r, stalls, last;
    bit rdy;
    bit plan [0:2047];
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 2048; i++) plan[i] = 1'($urandom_range(0, 1));
    if (k == 0) begin
      last = 1;
`ifdef SEQ_PERF_CNT_EN
      push(EV_DONE, t0 + 1, 1, 0);
`else
      push(EV_DONE, t0 + 1, 0, 0);
`endif
    end else begin
      push(EV_CLEAR, t0 + 1, 0, 0);
      for (int j = 0; j < k; j++)
        if (abort_rel == 0 || 2 + j <= abort_rel) push(EV_RD, t0 + 2 + j, j, 0);
      if (abort_rel != 0) begin
        last = abort_rel;
      end else begin
        c = k + 2 * N + 2; r = 0; stalls = 0;
        while (r < N) begin
          case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 99) < 65);
            2:       rdy = !(r == 1 && stalls < 3);
            default: rdy = 1'b1;
          endcase
          plan[c] = rdy;
          push(EV_ROW, t0 + c, r, 0);
          if (rdy) r++; else stalls++;
          c++;
        end
        last = c;
`ifdef SEQ_PERF_CNT_EN
        push(EV_DONE, t0 + c, c, stalls);
`else
        push(EV_DONE, t0 + c, 0, 0);
`endif
      end
    end
    cur_t0 = t0; cur_k = k; cur_last = last; cur_valid = 1'b1;
    start = 1'b1;
    k_len = K_W'(k);
    for (int rel = 1; rel <= last; rel++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 3) == 0);
      k_len     = K_W'($urandom);
      out_ready = plan[rel];
      if (abort_rel != 0 && rel == abort_rel) rst = 1'b1;
    end
    if (abort_rel != 0) begin
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({busy, done, clear_acc, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, out_valid, drain_row, feed_valid}),
          64'd0);
    check("reset_counters", {cycle_count, stall_count}, 64'd0);
    rst = 1'b0;

    run_tile(3, 0, 0);
    idle_cycles(2);
    run_tile(3, 2, 0);
    run_tile(0, 0, 0);
    idle_cycles(1);
    run_tile(10, 1, 5);
    run_tile(4, 0, 0);
    run_tile(255, 0, 0);
    run_tile(1, 1, 0);
    repeat (12) begin
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      run_tile($urandom_range(0, 20), 1, 0);
    end
    idle_cycles(6);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
